// File: rtl/alarm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alarm_pkg
// Purpose  : Shared types and constants for the alarm output driver:
//            FSM state encoding, register addresses, drive-mode encodings
//            and small decode helpers.
// Config   : ALARM_OUT_BLINK_EN - when defined, the BLINK_HI/BLINK_LO
//            states exist and MODE=1 selects blinking.
// Revision : 1.0 - initial release
// ============================================================================
package alarm_pkg;

  // Register map
  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_MODE   = 2'd1;
  localparam logic [1:0] ADDR_PERIOD = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  // Drive modes (3 is reserved and treated as steady)
  localparam logic [1:0] MODE_STEADY = 2'd0;
  localparam logic [1:0] MODE_BLINK  = 2'd1;
  localparam logic [1:0] MODE_PULSE  = 2'd2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    STEADY   = 3'd1,
    PULSE    = 3'd2
`ifdef ALARM_OUT_BLINK_EN
    ,
    BLINK_HI = 3'd3,
    BLINK_LO = 3'd4
`endif
  } alarm_state_e;

  // Entry state for a given drive mode.
  function automatic alarm_state_e first_state(input logic [1:0] mode);
    alarm_state_e s;
    case (mode)
      MODE_PULSE: s = PULSE;
`ifdef ALARM_OUT_BLINK_EN
      MODE_BLINK: s = BLINK_HI;
`endif
      default:    s = STEADY;
    endcase
    return s;
  endfunction

  // Output level associated with a state.
  function automatic logic drives_high(input alarm_state_e s);
    logic hi;
    case (s)
      STEADY:   hi = 1'b1;
      PULSE:    hi = 1'b1;
`ifdef ALARM_OUT_BLINK_EN
      BLINK_HI: hi = 1'b1;
`endif
      default:  hi = 1'b0;
    endcase
    return hi;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alarm_out_driver_if.sv
`default_nettype none
// ============================================================================
// Module   : alarm_out_driver_if
// Purpose  : Avalon-MM slave bus bundle for the alarm output driver.
// Signals  : chipselect, address[1:0], write_n, writedata[31:0] (master->slave)
//            readdata[31:0] (slave->master)
// Modports : master (CPU / bench side), slave (alarm_out_driver side)
// Revision : 1.0 - initial release
// ============================================================================
interface alarm_out_driver_if;
  logic        chipselect;
  logic [1:0]  address;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output chipselect, address, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  chipselect, address, write_n, writedata,
    output readdata
  );
endinterface
`default_nettype wire

// File: rtl/alarm_phase_timer.sv
`default_nettype none
// ============================================================================
// Module   : alarm_phase_timer
// Purpose  : Loadable saturating down-counter timing blink phases and pulses.
// Ports    : clk, reset_n (async active-low), load, load_val[CNT_W-1:0],
//            expired (count == 0)
// Revision : 1.0 - initial release
// ============================================================================
module alarm_phase_timer #(
  parameter int CNT_W = 25
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);

  logic [CNT_W-1:0] count;

  // Holds at zero rather than wrapping; load has priority.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign expired = (count == '0);

endmodule
`default_nettype wire

// File: rtl/alarm_out_driver.sv
`default_nettype none
// ============================================================================
// Module   : alarm_out_driver
// Purpose  : Avalon-MM writable slave generating the alarm sounder/LED
//            output autonomously in steady, blink or one-shot pulse mode.
// Ports    : clk, reset_n (async active-low), bus (alarm_out_driver_if.slave),
//            out_port (registered alarm output, 1 = sounding)
// Regs     : 0 CTRL (bit0 arm; reads out_port), 1 MODE, 2 PERIOD,
//            3 STATUS (reads {done, active}; any write clears done)
// Config   : ALARM_OUT_BLINK_EN - enables blink mode; otherwise MODE=1
//            behaves as steady.
// Revision : 1.0 - initial release
// ============================================================================
module alarm_out_driver
  import alarm_pkg::*;
#(
  parameter int CNT_W        = 25,
  parameter int RESET_PERIOD = 25_000_000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  alarm_out_driver_if.slave    bus,
  output logic                 out_port
);

  alarm_state_e     state, state_nxt;
  logic             arm, arm_nxt;
  logic [1:0]       mode;
  logic [CNT_W-1:0] period;
  logic             done;
  logic             done_set;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic [CNT_W-1:0] eff_load;
  logic             expired;
  logic             wr, wr_ctrl, wr_mode, wr_period, wr_status;
  logic             active;

  assign wr        = bus.chipselect && !bus.write_n;
  assign wr_ctrl   = wr && (bus.address == ADDR_CTRL);
  assign wr_mode   = wr && (bus.address == ADDR_MODE);
  assign wr_period = wr && (bus.address == ADDR_PERIOD);
  assign wr_status = wr && (bus.address == ADDR_STATUS);
  assign active    = (state != IDLE);

  // A zero PERIOD behaves as one clock.
  assign eff_load = (period == '0) ? '0 : period - CNT_W'(1);

  alarm_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (load),
    .load_val (load_val),
    .expired  (expired)
  );

  // Bus writes are evaluated before counter expiry so a write always wins.
  always_comb begin
    state_nxt = state;
    arm_nxt   = arm;
    load      = 1'b0;
    load_val  = eff_load;
    done_set  = 1'b0;
    if (wr_ctrl) begin
      arm_nxt = bus.writedata[0];
      if (!bus.writedata[0]) begin
        state_nxt = IDLE;
        load      = 1'b1;
        load_val  = '0;
      end else if (state == IDLE) begin
        state_nxt = first_state(mode);
        load      = 1'b1;
      end else if (state == PULSE) begin
        load      = 1'b1;                 // retrigger
      end
    end else if (wr_mode && arm) begin
      state_nxt = first_state(bus.writedata[1:0]);
      load      = 1'b1;
    end else if (expired) begin
      case (state)
        PULSE: begin
          state_nxt = IDLE;
          arm_nxt   = 1'b0;
          done_set  = 1'b1;
        end
`ifdef ALARM_OUT_BLINK_EN
        BLINK_HI: begin
          state_nxt = BLINK_LO;
          load      = 1'b1;
        end
        BLINK_LO: begin
          state_nxt = BLINK_HI;
          load      = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      arm          <= 1'b0;
      mode         <= MODE_STEADY;
      period       <= CNT_W'(RESET_PERIOD);
      done         <= 1'b0;
      out_port     <= 1'b0;
      bus.readdata <= '0;
    end else begin
      state    <= state_nxt;
      arm      <= arm_nxt;
      out_port <= drives_high(state_nxt);
      if (wr_mode)   mode   <= bus.writedata[1:0];
      if (wr_period) period <= bus.writedata[CNT_W-1:0];
      // Set beats a same-cycle STATUS-write clear.
      if (done_set)       done <= 1'b1;
      else if (wr_status) done <= 1'b0;
      case (bus.address)
        ADDR_CTRL:   bus.readdata <= {31'b0, out_port};
        ADDR_MODE:   bus.readdata <= {30'b0, mode};
        ADDR_PERIOD: bus.readdata <= 32'(period);
        default:     bus.readdata <= {30'b0, done, active};
      endcase
    end
  end

  // Write-data bits above the period width are intentionally ignored.
  generate
    if (CNT_W < 32) begin : g_unused_hi
      logic unused_writedata_hi;
      assign unused_writedata_hi = ^bus.writedata[31:CNT_W];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_alarm_out_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_alarm_out_driver
// Purpose  : Directed self-checking bench for alarm_out_driver: reset values,
//            steady, pulse, zero period, retrigger, blink and async reset.
// Config   : ALARM_OUT_BLINK_EN selects blink or steady expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alarm_out_driver;
  import alarm_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic out_port;
  int   n_checks = 0;
  int   n_fail   = 0;

  alarm_out_driver_if bus();

  alarm_out_driver #(.CNT_W(25), .RESET_PERIOD(25_000_000)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .out_port (out_port)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Write is sampled on the posedge between the two negedges; returns at the
  // negedge after it, where out_port already reflects the write.
  task automatic write_reg(input logic [1:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.chipselect = 1'b1;
    bus.address    = addr;
    bus.write_n    = 1'b0;
    bus.writedata  = data;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic read_reg(input logic [1:0] addr, output logic [31:0] data);
    @(negedge clk);
    bus.address = addr;
    @(negedge clk);
    data = bus.readdata;
  endtask

  initial begin
    logic [31:0] rd;
    logic [11:0] exp_blink;
    int          hi_cnt;

    bus.chipselect = 1'b0;
    bus.address    = ADDR_CTRL;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;

    // Reset
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    check("rst_out_port", {31'b0, out_port}, 32'd0);
    check("rst_readdata", bus.readdata, 32'd0);
    read_reg(ADDR_PERIOD, rd);
    check("rst_period", rd, 32'd25_000_000);

    // Steady
    write_reg(ADDR_MODE, 32'd0);
    write_reg(ADDR_CTRL, 32'd1);
    check("steady_on", {31'b0, out_port}, 32'd1);
    read_reg(ADDR_STATUS, rd);
    check("steady_status", rd, 32'd1);
    write_reg(ADDR_CTRL, 32'd0);
    check("steady_off", {31'b0, out_port}, 32'd0);
    read_reg(ADDR_STATUS, rd);
    check("off_status", rd, 32'd0);

    // Pulse of 5 clocks
    write_reg(ADDR_PERIOD, 32'd5);
    write_reg(ADDR_MODE, 32'd2);
    write_reg(ADDR_CTRL, 32'd1);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("pulse_hi_%0d", i), {31'b0, out_port}, 32'd1);
      @(negedge clk);
    end
    check("pulse_end", {31'b0, out_port}, 32'd0);
    read_reg(ADDR_STATUS, rd);
    check("pulse_done_status", rd, 32'd2);
    read_reg(ADDR_CTRL, rd);
    check("pulse_ctrl_read", rd, 32'd0);
    write_reg(ADDR_STATUS, 32'd0);
    read_reg(ADDR_STATUS, rd);
    check("done_cleared", rd, 32'd0);

    // Zero period gives a 1-clock pulse
    write_reg(ADDR_PERIOD, 32'd0);
    write_reg(ADDR_CTRL, 32'd1);
    check("p0_hi", {31'b0, out_port}, 32'd1);
    @(negedge clk);
    check("p0_lo", {31'b0, out_port}, 32'd0);

    // Retrigger at clock 3 of a 5-clock pulse: 3 + 5 = 8 high clocks
    write_reg(ADDR_PERIOD, 32'd5);
    write_reg(ADDR_CTRL, 32'd1);
    hi_cnt = 0;
    for (int c = 1; c <= 40; c++) begin
      if (!out_port) break;
      hi_cnt++;
      if (c == 3) begin
        bus.chipselect = 1'b1;
        bus.address    = ADDR_CTRL;
        bus.write_n    = 1'b0;
        bus.writedata  = 32'd1;
      end else begin
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
      end
      @(negedge clk);
    end
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    check("retrigger_len", 32'(hi_cnt), 32'd8);

    // Blink with half-period 3
    write_reg(ADDR_PERIOD, 32'd3);
    write_reg(ADDR_MODE, 32'd1);
    write_reg(ADDR_CTRL, 32'd1);
`ifdef ALARM_OUT_BLINK_EN
    exp_blink = 12'b111000111000;
`else
    exp_blink = 12'b111111111111;
`endif
    for (int i = 0; i < 12; i++) begin
      check($sformatf("blink_%0d", i), {31'b0, out_port}, {31'b0, exp_blink[11-i]});
      @(negedge clk);
    end

    // Async reset while out_port is high (clock 13 of the pattern)
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_out", {31'b0, out_port}, 32'd0);
    check("async_rst_rd", bus.readdata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    read_reg(ADDR_MODE, rd);
    check("post_rst_mode", rd, 32'd0);
    read_reg(ADDR_STATUS, rd);
    check("post_rst_status", rd, 32'd0);
    check("post_rst_out", {31'b0, out_port}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
